// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, instruction opcodes and the TMS-driven state graph.
package jtag_pkg;
    localparam int IR_LEN_DEFAULT = 4;

    localparam logic [3:0] OP_IDCODE = 4'h1;
    localparam logic [3:0] OP_USER   = 4'h2;
    localparam logic [3:0] OP_BYPASS = 4'hF;

    // Encodings follow the customary 1149.1 assignment.
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR    : RTI;
            RTI:     tap_next = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms ? UPD_DR : PA_DR;
            PA_DR:   tap_next = tms ? EX2_DR : PA_DR;
            EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms ? UPD_IR : PA_IR;
            PA_IR:   tap_next = tms ? EX2_IR : PA_IR;
            EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction
endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchronizer plus one history flop; flags a rise or fall of the synced level.
module jtag_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic meta, sync_q, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    // sync_q and prev differ in one direction only, so rise and fall are exclusive.
    assign rise = sync_q & ~prev;
    assign fall = ~sync_q & prev;
endmodule

// File: rtl/jtag_tap_target.sv
// JTAG TAP controller oversampled on clk: IR, IDCODE, BYPASS and a USER data register.
module jtag_tap_target
    import jtag_pkg::*;
#(
    parameter int          IR_LEN     = IR_LEN_DEFAULT,
    parameter int          DR_LEN     = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              TCK,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    output logic              TDO_OE,
    input  logic [DR_LEN-1:0] user_capture_data,
    output logic [DR_LEN-1:0] user_update_data,
    output logic              user_update_valid,
    output logic [IR_LEN-1:0] ir_value,
    output logic [3:0]        tap_state
);
    logic tck_rise, tck_fall;
    logic tms_meta, tms_s, tdi_meta, tdi_s;

    tap_state_t        state, nxt;
    logic [IR_LEN-1:0] ir_sr;
    logic [31:0]       id_sr;
    logic [DR_LEN-1:0] user_sr;
    logic              byp_sr;
    logic              sel_id, sel_user;

    jtag_sync_edge u_tck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (TCK),
        .rise  (tck_rise),
        .fall  (tck_fall)
    );

    // TMS/TDI share TCK's two-flop depth so they line up with the detected rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tms_meta <= 1'b0;
            tms_s    <= 1'b0;
            tdi_meta <= 1'b0;
            tdi_s    <= 1'b0;
        end else begin
            tms_meta <= TMS;
            tms_s    <= tms_meta;
            tdi_meta <= TDI;
            tdi_s    <= tdi_meta;
        end
    end

    assign nxt       = tap_next(state, tms_s);
    assign sel_id    = (ir_value == IR_LEN'(OP_IDCODE));
    assign sel_user  = (ir_value == IR_LEN'(OP_USER));
    assign tap_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= TLR;
            ir_value          <= IR_LEN'(OP_IDCODE);
            ir_sr             <= '0;
            id_sr             <= '0;
            user_sr           <= '0;
            byp_sr            <= 1'b0;
            user_update_data  <= '0;
            user_update_valid <= 1'b0;
            TDO               <= 1'b0;
            TDO_OE            <= 1'b0;
        end else begin
            user_update_valid <= 1'b0;
            if (tck_rise) begin
                case (state)
                    CAP_IR: ir_sr <= IR_LEN'(1);
                    SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
                    UPD_IR: ir_value <= ir_sr;
                    CAP_DR: begin
                        if (sel_user)    user_sr <= user_capture_data;
                        else if (sel_id) id_sr   <= IDCODE_VAL;
                        else             byp_sr  <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_user)    user_sr <= {tdi_s, user_sr[DR_LEN-1:1]};
                        else if (sel_id) id_sr   <= {tdi_s, id_sr[31:1]};
                        else             byp_sr  <= tdi_s;
                    end
                    UPD_DR: begin
                        if (sel_user) begin
                            user_update_data  <= user_sr;
                            user_update_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                // UPD_IR never leads to TLR, so this cannot clash with the IR update above.
                if (nxt == TLR) ir_value <= IR_LEN'(OP_IDCODE);
                state  <= nxt;
                TDO_OE <= (nxt == SH_IR) || (nxt == SH_DR);
            end else if (tck_fall) begin
                if (state == SH_IR)      TDO <= ir_sr[0];
                else if (state == SH_DR) TDO <= sel_user ? user_sr[0] : (sel_id ? id_sr[0] : byp_sr);
                else                     TDO <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jtag_tap_target.sv
// Randomized bench: TAP state graph table plus a queue model of register scans.
module tb_jtag_tap_target;
    import jtag_pkg::*;

    localparam logic [31:0] IDV = 32'h1000_0001;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        TCK = 1'b0, TMS = 1'b0, TDI = 1'b0;
    logic        TDO, TDO_OE, user_update_valid;
    logic [31:0] user_capture_data = '0, user_update_data;
    logic [3:0]  ir_value, tap_state;

    jtag_tap_target #(.IR_LEN(4), .DR_LEN(32), .IDCODE_VAL(IDV)) dut (
        .clk(clk), .rst_n(rst_n), .TCK(TCK), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_OE(TDO_OE),
        .user_capture_data(user_capture_data), .user_update_data(user_update_data),
        .user_update_valid(user_update_valid), .ir_value(ir_value), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0, n_pulse = 0;
    logic [3:0] exp_state, exp_ir;
    logic [3:0] nx0 [16], nx1 [16];
    logic       last_tdo;

    always @(posedge clk) if (user_update_valid) n_pulse++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Standard TAP graph as (tms=0, tms=1) successors.
    task automatic fill_graph();
        nx0[TLR] = RTI;       nx1[TLR] = TLR;
        nx0[RTI] = RTI;       nx1[RTI] = SEL_DR;
        nx0[SEL_DR] = CAP_DR; nx1[SEL_DR] = SEL_IR;
        nx0[CAP_DR] = SH_DR;  nx1[CAP_DR] = EX1_DR;
        nx0[SH_DR] = SH_DR;   nx1[SH_DR] = EX1_DR;
        nx0[EX1_DR] = PA_DR;  nx1[EX1_DR] = UPD_DR;
        nx0[PA_DR] = PA_DR;   nx1[PA_DR] = EX2_DR;
        nx0[EX2_DR] = SH_DR;  nx1[EX2_DR] = UPD_DR;
        nx0[UPD_DR] = RTI;    nx1[UPD_DR] = SEL_DR;
        nx0[SEL_IR] = CAP_IR; nx1[SEL_IR] = TLR;
        nx0[CAP_IR] = SH_IR;  nx1[CAP_IR] = EX1_IR;
        nx0[SH_IR] = SH_IR;   nx1[SH_IR] = EX1_IR;
        nx0[EX1_IR] = PA_IR;  nx1[EX1_IR] = UPD_IR;
        nx0[PA_IR] = PA_IR;   nx1[PA_IR] = EX2_IR;
        nx0[EX2_IR] = SH_IR;  nx1[EX2_IR] = UPD_IR;
        nx0[UPD_IR] = RTI;    nx1[UPD_IR] = SEL_DR;
    endtask

    // One full TCK period; TDO is read after the falling edge has propagated.
    task automatic tck_cycle(input logic tms, input logic tdi);
        logic in_shift;
        @(negedge clk); TMS = tms; TDI = tdi;
        repeat (4) @(negedge clk); TCK = 1'b1;
        repeat (4) @(negedge clk); TCK = 1'b0;
        repeat (4) @(negedge clk);
        exp_state = tms ? nx1[exp_state] : nx0[exp_state];
        in_shift  = (exp_state == SH_DR) || (exp_state == SH_IR);
        last_tdo  = TDO;
        chk("tap_state", 64'(tap_state), 64'(exp_state));
        chk("tdo_oe", 64'(TDO_OE), 64'(in_shift));
        if (!in_shift) chk("tdo_idle", 64'(TDO), 64'd0);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din, input logic exit_last,
                              output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = last_tdo;
            tck_cycle(exit_last && (i == n - 1), din[i]);
        end
    endtask

    // Scan as a FIFO of len bits: each shift emits the front bit and appends TDI.
    function automatic void model_scan(input logic [63:0] cap, input int len, input logic [63:0] din,
                                       input int n, output logic [63:0] dout, output logic [63:0] fin);
        logic q[$];
        for (int i = 0; i < len; i++) q.push_back(cap[i]);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = q.pop_front();
            q.push_back(din[i]);
        end
        fin = '0;
        for (int i = 0; i < len; i++) fin[i] = q[i];
    endfunction

    function automatic void dr_sel(output logic [63:0] cap, output int len);
        if (exp_ir == 4'h1)      begin cap = 64'(IDV); len = 32; end
        else if (exp_ir == 4'h2) begin cap = 64'(user_capture_data); len = 32; end
        else                     begin cap = '0; len = 1; end
    endfunction

    task automatic ir_scan(input logic [3:0] op);
        logic [63:0] out, eo, ef;
        tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
        shift_bits(4, 64'(op), 1'b1, out);
        tck_cycle(1, 0); tck_cycle(0, 0);
        model_scan(64'h1, 4, 64'(op), 4, eo, ef);
        exp_ir = op;
        chk("ir_capture", out, eo);
        chk("ir_value", 64'(ir_value), 64'(exp_ir));
    endtask

    task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] out);
        logic [63:0] cap, eo, ef;
        int len, p0;
        dr_sel(cap, len);
        p0 = n_pulse;
        tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
        shift_bits(n, din, 1'b1, out);
        tck_cycle(1, 0); tck_cycle(0, 0);
        model_scan(cap, len, din, n, eo, ef);
        chk("dr_out", out, eo);
        chk("upd_pulses", 64'(n_pulse - p0), (exp_ir == 4'h2) ? 64'd1 : 64'd0);
        if (exp_ir == 4'h2) chk("upd_data", 64'(user_update_data), ef);
    endtask

    initial begin
        logic [63:0] out, o1, o2, din, eo, ef;
        logic [3:0]  op;
        int p0, n;
        fill_graph();
        repeat (4) @(negedge clk);
        chk("rst_state", 64'(tap_state), 64'hF);
        chk("rst_ir", 64'(ir_value), 64'h1);
        chk("rst_oe", 64'(TDO_OE), 64'd0);
        chk("rst_tdo", 64'(TDO), 64'd0);
        chk("rst_upd", 64'(user_update_data), 64'd0);
        chk("rst_valid", 64'(user_update_valid), 64'd0);
        rst_n = 1'b1;
        exp_state = TLR; exp_ir = 4'h1;

        // Random walk, then five TMS=1 rises must land in TLR from wherever it ended.
        for (int i = 0; i < 30; i++) tck_cycle(1'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) tck_cycle(1, 0);
        exp_ir = 4'h1;
        chk("tlr_state", 64'(tap_state), 64'hF);
        chk("tlr_ir", 64'(ir_value), 64'h1);
        chk("tlr_oe", 64'(TDO_OE), 64'd0);
        tck_cycle(0, 0);

        dr_scan(32, {$urandom, $urandom}, out);
        chk("idcode", out, 64'h1000_0001);

        user_capture_data = 32'h1234_5678;
        ir_scan(4'h2);
        chk("ir_user", 64'(ir_value), 64'h2);
        dr_scan(32, 64'hDEAD_BEEF, out);
        chk("user_out", out, 64'h1234_5678);
        chk("user_upd", 64'(user_update_data), 64'hDEAD_BEEF);

        ir_scan(4'h7);
        dr_scan(8, 64'hA5, out);
        chk("bypass_out", out, 64'h4A);

        // Split 16+16 scan with a 10-TCK pause in between.
        user_capture_data = $urandom;
        din = 64'($urandom);
        ir_scan(4'h2);
        model_scan(64'(user_capture_data), 32, din, 32, eo, ef);
        p0 = n_pulse;
        tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
        shift_bits(16, din, 1'b1, o1);
        for (int i = 0; i < 11; i++) tck_cycle(0, 0);
        tck_cycle(1, 0); tck_cycle(0, 0);
        shift_bits(16, din >> 16, 1'b1, o2);
        tck_cycle(1, 0); tck_cycle(0, 0);
        chk("pause_out", (o2 << 16) | o1, eo);
        chk("pause_upd", 64'(user_update_data), ef);
        chk("pause_pulse", 64'(n_pulse - p0), 64'd1);

        // Reset mid-scan at bit 10.
        p0 = n_pulse;
        tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
        shift_bits(10, 64'($urandom), 1'b0, out);
        @(negedge clk); TMS = 1'b0; TDI = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_state = TLR; exp_ir = 4'h1;
        for (int i = 0; i < 3; i++) tck_cycle(1, 0);
        chk("abort_state", 64'(tap_state), 64'hF);
        chk("abort_ir", 64'(ir_value), 64'h1);
        chk("abort_pulse", 64'(n_pulse - p0), 64'd0);
        chk("abort_upd", 64'(user_update_data), 64'd0);
        tck_cycle(0, 0);

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: op = 4'h1;
                1: op = 4'h2;
                2: op = 4'hF;
                default: op = 4'($urandom);
            endcase
            user_capture_data = $urandom;
            ir_scan(op);
            n = $urandom_range(1, 40);
            dr_scan(n, {$urandom, $urandom}, out);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jtag_tap_target.md
JTAG_TAP_TARGET -- requirements
Module: jtag_tap_target

Interface
REQ-001 Parameter IR_LEN, default 4, instruction register width in bits.
REQ-002 Parameter DR_LEN, default 32, user data register width in bits.
REQ-003 Parameter IDCODE_VAL, default 32'h1000_0001, IDCODE register contents; bit 0 SHALL be 1.
REQ-004 clk  input  1  system clock; the block SHALL run on this one clock only.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 TCK  input  1  JTAG test clock, asynchronous to clk, oversampled.
REQ-007 TMS  input  1  JTAG mode select, asynchronous to clk.
REQ-008 TDI  input  1  JTAG serial data in, LSB-first.
REQ-009 TDO  output  1  JTAG serial data out, LSB-first.
REQ-010 TDO_OE  output  1  high only while in Shift-IR or Shift-DR.
REQ-011 user_capture_data  input  DR_LEN  parallel value loaded into the USER DR at Capture-DR.
REQ-012 user_update_data  output  DR_LEN  USER DR contents latched at Update-DR.
REQ-013 user_update_valid  output  1  one-clk pulse when user_update_data changes.
REQ-014 ir_value  output  IR_LEN  current active instruction.
REQ-015 tap_state  output  4  current TAP state encoding.

Function
REQ-016 TCK, TMS and TDI SHALL pass through 2-flop synchronizers; TCK rise/fall SHALL be detected by comparing the synced value with a registered copy.
REQ-017 TCK frequency SHALL be at most clk/4; the synchronizer SHALL not filter edges.
REQ-018 On a detected TCK rise, the block SHALL sample TMS/TDI, perform the shift and advance the state in the same clk cycle. Total latency from the TCK pin edge SHALL be 3 clk.
REQ-019 The FSM SHALL implement all 16 IEEE 1149.1 TAP states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR. Transitions SHALL follow TMS exactly as in the standard.
REQ-020 Five consecutive TCK rises with TMS=1 SHALL reach TLR from any state.
REQ-021 In TLR, ir_value SHALL be IDCODE (4'h1).
REQ-022 Opcodes: IDCODE=4'h1, USER=4'h2, BYPASS=4'hF. Any other opcode SHALL select BYPASS.
REQ-023 CAP_IR SHALL load the IR shift register with 4'b0001 (LSBs 01).
REQ-024 CAP_DR SHALL load the selected DR: IDCODE_VAL, user_capture_data, or 1'b0 for BYPASS.
REQ-025 In SH_IR/SH_DR, each rise SHALL shift right, with TDI entering the MSB of the selected register.
REQ-026 The final shift bit SHALL be the rise on which TMS=1 moves the FSM to EX1.
REQ-027 The shift register SHALL hold its value through PA/EX2; re-entering shift SHALL continue from the held value.
REQ-028 UPD_IR SHALL copy the IR shift register to ir_value.
REQ-029 UPD_DR with USER active SHALL copy the shift register to user_update_data and pulse user_update_valid for exactly one clk.
REQ-030 On a detected TCK fall, TDO SHALL be driven with the LSB of the active shift register in shift states and 0 elsewhere.
REQ-031 Simultaneous events: TCK rise and fall SHALL never be detected in the same clk; a fall SHALL use the post-rise register contents.

Reset
REQ-032 While rst_n=0, the following SHALL hold: state=TLR, ir_value=4'h1, all shift registers 0, user_update_data 0, user_update_valid 0, TDO 0, TDO_OE 0, synchronizer flops 0.
REQ-033 rst_n asserted mid-shift SHALL abort the scan with no update pulse; the first clk after deassertion SHALL see no spurious TCK edge.

Structure
REQ-034 Package jtag_pkg SHALL hold tap_state_t (4-bit enum, TLR=4'hF, RTI=4'hC), the instruction opcode constants and IR_LEN_DEFAULT.
REQ-035 Sub-module jtag_sync_edge SHALL implement the synchronizer and rise/fall detection, instantiated once for TCK; the FSM and registers SHALL live in the top module.

Verification
REQ-036 Power-on reset, then 5 TCK with TMS=1 -> tap_state=TLR, ir_value=4'h1, TDO_OE=0.
REQ-037 From RTI, TMS 1,0,0 then 32 shift clocks with TMS=1 on the last -> TDO stream equals 32'h1000_0001 LSB-first.
REQ-038 Shift-IR of 4'h2, then Shift-DR of 32'hDEAD_BEEF with user_capture_data=32'h1234_5678 -> TDO=32'h1234_5678, user_update_data=32'hDEADBEEF, one user_update_valid pulse.
REQ-039 Shift-IR 4'h7 (unknown), then Shift-DR of 8 bits 8'hA5 -> TDO is a 0 followed by the first 7 TDI bits (one-bit delay).
REQ-040 Shift-DR USER 16 bits, Pause-DR 10 TCK, resume 16 bits -> update equals the concatenated 32 bits.
REQ-041 rst_n pulsed low during Shift-DR bit 10 -> tap_state=TLR, no user_update_valid pulse.
